multi_cycle_processor: RTL

MULTI_CYCLE_PROCESSOR -- requirements
Module: multi_cycle_processor

---
 rtl/multi_cycle_processor.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/multi_cycle_processor.sv
// Three-state (fetch / execute / write-back) 8-bit-instruction processor with
// an 8-entry register file, PC-relative branches and a combinational debug read.
module multi_cycle_processor #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    output logic              Imem_Req,
    output logic [PC_W-1:0]   Imem_Addr,
    input  logic              Imem_Valid,
    input  logic [7:0]        Imem_Rdata,
    input  logic [2:0]        Dbg_Sel,
    output logic [DATA_W-1:0] Dbg_Data,
    output logic [PC_W-1:0]   Pc,
    output logic              Retire
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_JMP  = 2'b10;
    localparam logic [1:0] OP_BZ   = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WB    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   npc_q, npc_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];

    logic              fetch_done;
    logic              exec_en;
    logic              wb_en;

    logic [1:0]        opcode;
    logic [2:0]        rd_idx;
    logic [2:0]        rs_idx;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] imm3_data;
    logic [PC_W-1:0]   imm3_pc;
    logic [PC_W-1:0]   imm6_pc;

    assign opcode    = ir_q[7:6];
    assign rd_idx    = ir_q[5:3];
    assign rs_idx    = ir_q[2:0];
    assign rd_val    = regs_q[rd_idx];
    assign rs_val    = regs_q[rs_idx];
    assign imm3_data = DATA_W'($signed(ir_q[2:0]));
    assign imm3_pc   = PC_W'($signed(ir_q[2:0]));
    assign imm6_pc   = PC_W'($signed(ir_q[5:0]));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: if (Imem_Valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        Imem_Req   = 1'b0;
        fetch_done = 1'b0;
        exec_en    = 1'b0;
        wb_en      = 1'b0;
        Retire     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                Imem_Req   = 1'b1;
                fetch_done = Imem_Valid;
            end
            S_EXEC:  exec_en = 1'b1;
            S_WB: begin
                wb_en  = 1'b1;
                Retire = 1'b1;
            end
            default: ;
        endcase
    end

    // Both ALU result and next PC are settled in EXEC, so WB only commits.
    always_comb begin
        ir_d  = fetch_done ? Imem_Rdata : ir_q;
        alu_d = alu_q;
        npc_d = npc_q;
        if (exec_en) begin
            alu_d = rd_val + ((opcode == OP_ADD) ? rs_val : imm3_data);
            unique case (opcode)
                OP_ADD, OP_ADDI: npc_d = pc_q + PC_W'(1);
                OP_JMP:          npc_d = pc_q + imm6_pc;
                OP_BZ:           npc_d = (rd_val == '0) ? (pc_q + imm3_pc)
                                                        : (pc_q + PC_W'(1));
                default:         npc_d = pc_q + PC_W'(1);
            endcase
        end
        pc_d = wb_en ? npc_q : pc_q;
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wb_en && !opcode[1]) begin
            regs_d[rd_idx] = alu_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q  <= '0;
            npc_q <= '0;
            ir_q  <= '0;
            alu_q <= '0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
            ir_q  <= ir_d;
            alu_q <= alu_d;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign Imem_Addr = pc_q;
    assign Pc        = pc_q;
    assign Dbg_Data  = regs_q[Dbg_Sel];

endmodule
